hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline hazard and sequencing controller for the 5-stage MIPS core (IF/ID/EX/MEM/WB). It tracks destination-register metadata of in-flight instructions and generates the stall, bubble and flush controls plus registered forwarding selects. It also runs a busy counter for the multicycle mult/div unit that gates HI/LO access. It sits beside the decoder and drives the IF/ID and ID/EX pipeline-register enables.

Parameters:
REG_W, 5, register-index width
MULT_LAT, 4, cycles mult/multu occupies HI/LO after issue to EX
DIV_LAT, 32, cycles div/divu occupies HI/LO after issue to EX

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_rs, id_rt  in  REG_W  ID source indices
id_uses_rs, id_uses_rt  in  1  operand actually read
id_dest  in  REG_W  ID destination index (rd/rt/31 already muxed)
id_we  in  1  ID writes GPR
id_is_load  in  1  ID is lw/lb/lbu/lh/lhu
id_md_start  in  1  ID is mult/multu/div/divu
id_md_div  in  1  qualifies id_md_start: 1=div, 0=mult
id_hilo_rd  in  1  ID is mfhi/mflo/mthi/mtlo
ex_redirect  in  1  branch/jump/jr/jalr resolved taken in EX
stall_if_id  out  1  hold PC and IF/ID
bubble_ex  out  1  load nop into ID/EX next edge
flush_if_id  out  1  kill IF/ID contents next edge
fwd_a_sel, fwd_b_sel  out  2  EX operand source: 00 regfile, 01 MEM result, 10 WB result
md_busy  out  1  mult/div unit occupied

Behaviour:
- Reset (async): all tracked entries invalid, md counter 0, fwd_*_sel=00, md_busy=0. Combinational outputs (stall_if_id, bubble_ex, flush_if_id) are 0 while rst is asserted.
- Tracked entries: EX, MEM, WB, each holding {valid, dest, we, is_load}. Every edge: WB<=MEM, MEM<=EX. EX<=ID fields only when ID advances; otherwise EX<=invalid (bubble).
- Hazard qualifier: a match requires valid & we & dest!=0 & dest==src & uses_src. $0 never hazards.
- Load-use: an EX entry with is_load matching id_rs or id_rt causes stall_if_id=1 and bubble_ex=1 for exactly 1 cycle.
- HI/LO: (id_hilo_rd | id_md_start) & md_busy causes stall_if_id=1 and bubble_ex=1 until md_busy falls.
- Redirect: ex_redirect causes flush_if_id=1 and bubble_ex=1, and stall_if_id is forced 0. Redirect has priority over every stall; a wrong-path ID instruction never issues, never starts md, and never loads an EX entry.
- ID advances when id_valid & !stall_if_id & !ex_redirect.
- Forwarding selects are registered on each edge and become valid when the instruction enters EX.
  - A non-load EX entry match gives 01.
  - Otherwise a MEM entry match gives 10.
  - Otherwise 00. The newest producer wins.
  - A load never forwards from MEM, because the stall guarantees it has reached WB.
  - Selects are 00 whenever a bubble enters EX.
- md counter: on ID advance with id_md_start, load MULT_LAT or DIV_LAT. Otherwise decrement while nonzero. md_busy = (counter!=0).
- Redirect with a new md_start in ID: no load. An already-running count continues.
- Simultaneous load-use and HI/LO stall: a single combined stall; it releases when both conditions clear.
- Reset mid-operation: the counter and all entries clear immediately, with no residual stall.

Decomposition:
- Shared include header: FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10, REG_ZERO, and the pipeline-entry field layout.
- One sub-module: md_busy_ctr (load/decrement counter with busy output, parameterised by MULT_LAT/DIV_LAT).
- Hazard comparators and entry shift stay inline.

Test Plan:
1. lw t0,0(t1) (0x8D280000) followed by addu t2,t0,t1 (0x01095021) -> stall_if_id=bubble_ex=1 for 1 cycle; addu in EX sees fwd_a_sel=10.
2. addu t0,t1,t2 (0x012A4021) followed by subu t3,t0,t0 (0x01085823) -> no stall; fwd_a_sel=fwd_b_sel=01. An intervening nop gives 10.
3. div t0,t1 (0x0109001A) followed by mflo t2 (0x00005012) -> stall for DIV_LAT cycles; mflo enters EX on the cycle after md_busy falls. The same with mult gives MULT_LAT.
4. ex_redirect=1 with the same cycle's ID instruction forming a load-use hazard -> flush_if_id=1, bubble_ex=1, stall_if_id=0; the next EX entry is invalid.
5. addu zero,t1,t2 (dest 0) followed by addu t3,zero,zero -> no stall; fwd selects 00.
6. rst pulsed at cycle 10 of a div -> md_busy=0 immediately; a following mflo issues with no stall.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding encodings,
// the tracked pipeline-entry layout and the dependency-match helper.
package hazard_ctrl_pkg;

  localparam int unsigned REG_IDX_W = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] dest;
    logic                 we;
    logic                 is_load;
  } pipe_entry_t;

  // $0 is hardwired, so a producer targeting it never creates a dependency.
  function automatic logic src_hit(input pipe_entry_t e, input logic [REG_IDX_W-1:0] src,
                                   input logic uses);
    return e.valid && e.we && (e.dest != REG_ZERO) && (e.dest == src) && uses;
  endfunction

  // Newest producer wins; a load still in EX cannot supply data next cycle.
  function automatic logic [1:0] fwd_pick(input pipe_entry_t ex_e, input pipe_entry_t mem_e,
                                          input logic [REG_IDX_W-1:0] src, input logic uses);
    if (src_hit(ex_e, src, uses) && !ex_e.is_load) return FWD_MEM;
    if (src_hit(mem_e, src, uses))                 return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_ctr.sv
// Occupancy counter for the multicycle mult/div unit; busy while the HI/LO
// result is still being produced.
module md_busy_ctr #(
  parameter int unsigned MULT_LAT = 4,
  parameter int unsigned DIV_LAT  = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline: load-use and
// HI/LO stalls, redirect flushes and registered EX forwarding selects.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_W    = REG_IDX_W,
  parameter int unsigned MULT_LAT = 4,
  parameter int unsigned DIV_LAT  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_we,
  input  logic             id_is_load,
  input  logic             id_md_start,
  input  logic             id_md_div,
  input  logic             id_hilo_rd,
  input  logic             ex_redirect,
  output logic             stall_if_id,
  output logic             bubble_ex,
  output logic             flush_if_id,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             md_busy
);

  // Only EX and MEM metadata is stored: a producer already in WB is never
  // compared against, since forwarding is chosen as the consumer enters EX.
  pipe_entry_t ex_q, mem_q;

  logic load_use, hilo_stall, advance;

  always_comb begin
    load_use    = id_valid && ex_q.is_load &&
                  (src_hit(ex_q, id_rs, id_uses_rs) || src_hit(ex_q, id_rt, id_uses_rt));
    hilo_stall  = id_valid && (id_hilo_rd || id_md_start) && md_busy;
    stall_if_id = !rst && !ex_redirect && (load_use || hilo_stall);
    bubble_ex   = !rst && (ex_redirect || load_use || hilo_stall);
    flush_if_id = !rst && ex_redirect;
    advance     = id_valid && !stall_if_id && !ex_redirect;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      fwd_a_sel <= FWD_RF;
      fwd_b_sel <= FWD_RF;
    end else begin
      mem_q <= ex_q;
      if (advance) begin
        ex_q      <= '{valid: 1'b1, dest: id_dest, we: id_we, is_load: id_is_load};
        fwd_a_sel <= fwd_pick(ex_q, mem_q, id_rs, id_uses_rs);
        fwd_b_sel <= fwd_pick(ex_q, mem_q, id_rt, id_uses_rt);
      end else begin
        ex_q      <= '0;
        fwd_a_sel <= FWD_RF;
        fwd_b_sel <= FWD_RF;
      end
    end
  end

  md_busy_ctr #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_md_busy_ctr (
    .clk    (clk),
    .rst    (rst),
    .start  (advance && id_md_start),
    .is_div (id_md_div),
    .busy   (md_busy)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a pipeline-occupancy model checks every cycle,
// plus literal expectations taken from the MIPS instruction sequences.
module tb_hazard_ctrl;

  localparam int MULT_LAT = 4;
  localparam int DIV_LAT  = 32;

  logic       clk, rst;
  logic       id_valid, id_uses_rs, id_uses_rt, id_we, id_is_load;
  logic       id_md_start, id_md_div, id_hilo_rd, ex_redirect;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       stall_if_id, bubble_ex, flush_if_id, md_busy;
  logic [1:0] fwd_a_sel, fwd_b_sel;

  hazard_ctrl #(.REG_W(5), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .id_dest     (id_dest),
    .id_we       (id_we),
    .id_is_load  (id_is_load),
    .id_md_start (id_md_start),
    .id_md_div   (id_md_div),
    .id_hilo_rd  (id_hilo_rd),
    .ex_redirect (ex_redirect),
    .stall_if_id (stall_if_id),
    .bubble_ex   (bubble_ex),
    .flush_if_id (flush_if_id),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel),
    .md_busy     (md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [4:0] rs, rt;
    logic       urs, urt;
    logic [4:0] dest;
    logic       we, ld, md, div, hilo;
  } ins_t;

  // Instruction as it sits in a pipeline stage, with the operand sources it
  // must be fed from once it is in EX.
  typedef struct packed {
    logic       v;
    logic [4:0] dest;
    logic       we, ld;
    logic [1:0] fa, fb;
  } rec_t;

  int   checks = 0;
  int   errors = 0;
  rec_t m_ex, m_mem, m_wb;
  int   cyc = 0;
  int   md_until = 0;
  logic last_adv;
  logic s_stall, s_bubble, s_flush;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic ins_t mk(input int rs, input int rt, input bit urs, input bit urt,
                              input int dest, input bit we, input bit ld, input bit md,
                              input bit div, input bit hilo);
    ins_t i;
    i.v = 1'b1; i.rs = 5'(rs); i.rt = 5'(rt); i.urs = urs; i.urt = urt;
    i.dest = 5'(dest); i.we = we; i.ld = ld; i.md = md; i.div = div; i.hilo = hilo;
    return i;
  endfunction

  function automatic bit produces(input rec_t r, input logic [4:0] src, input logic uses);
    return r.v && r.we && (r.dest != 5'd0) && (r.dest == src) && uses;
  endfunction

  // Source of an operand for the instruction now in EX, judged by what is ahead.
  function automatic logic [1:0] src_of(input rec_t mem_r, input rec_t wb_r,
                                        input logic [4:0] src, input logic uses);
    if (produces(mem_r, src, uses) && !mem_r.ld) return 2'b01;
    if (produces(wb_r, src, uses)) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_clear();
    m_ex = '0; m_mem = '0; m_wb = '0; md_until = 0;
  endtask

  task automatic step(input ins_t in, input logic redir);
    bit   busy, ld_use, hl, e_stall, e_bubble, adv;
    rec_t nr;
    id_valid = in.v; id_rs = in.rs; id_rt = in.rt; id_uses_rs = in.urs; id_uses_rt = in.urt;
    id_dest = in.dest; id_we = in.we; id_is_load = in.ld; id_md_start = in.md;
    id_md_div = in.div; id_hilo_rd = in.hilo; ex_redirect = redir;
    #1;
    if (rst) model_clear();
    busy     = (cyc < md_until);
    ld_use   = in.v && m_ex.ld &&
               (produces(m_ex, in.rs, in.urs) || produces(m_ex, in.rt, in.urt));
    hl       = in.v && (in.hilo || in.md) && busy;
    e_stall  = !rst && !redir && (ld_use || hl);
    e_bubble = !rst && (redir || ld_use || hl);
    adv      = !rst && in.v && !e_stall && !redir;
    chk("stall_if_id", int'(stall_if_id), int'(e_stall));
    chk("bubble_ex", int'(bubble_ex), int'(e_bubble));
    chk("flush_if_id", int'(flush_if_id), int'(!rst && redir));
    chk("md_busy", int'(md_busy), int'(busy));
    chk("fwd_a_sel", int'(fwd_a_sel), m_ex.v ? int'(m_ex.fa) : 0);
    chk("fwd_b_sel", int'(fwd_b_sel), m_ex.v ? int'(m_ex.fb) : 0);
    s_stall = stall_if_id; s_bubble = bubble_ex; s_flush = flush_if_id;
    last_adv = adv;
    @(posedge clk);
    cyc++;
    if (rst) begin
      model_clear();
    end else begin
      m_wb  = m_mem;
      m_mem = m_ex;
      nr    = '0;
      if (adv) begin
        nr.v = 1'b1; nr.dest = in.dest; nr.we = in.we; nr.ld = in.ld;
        nr.fa = src_of(m_mem, m_wb, in.rs, in.urs);
        nr.fb = src_of(m_mem, m_wb, in.rt, in.urt);
        if (in.md) md_until = cyc + (in.div ? DIV_LAT : MULT_LAT);
      end
      m_ex = nr;
    end
    @(negedge clk);
  endtask

  task automatic issue(input ins_t in, output int stalls);
    bit done = 0;
    stalls = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      step(in, 1'b0);
      if (last_adv) done = 1;
      else stalls++;
    end
    if (!done) chk("issue_timeout", 1, 0);
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) step('0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ins_t lw_t0, addu_t2_t0_t1, addu_t0_t1_t2, subu_t3_t0_t0, nop, addu_z, addu_t3_zz;
    ins_t div_t0_t1, mult_t0_t1, mflo_t2, mthi_t0;
    int   n;
    lw_t0         = mk(9, 0, 1, 0, 8, 1, 1, 0, 0, 0);
    addu_t2_t0_t1 = mk(8, 9, 1, 1, 10, 1, 0, 0, 0, 0);
    addu_t0_t1_t2 = mk(9, 10, 1, 1, 8, 1, 0, 0, 0, 0);
    subu_t3_t0_t0 = mk(8, 8, 1, 1, 11, 1, 0, 0, 0, 0);
    nop           = mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    addu_z        = mk(9, 10, 1, 1, 0, 1, 0, 0, 0, 0);
    addu_t3_zz    = mk(0, 0, 1, 1, 11, 1, 0, 0, 0, 0);
    div_t0_t1     = mk(8, 9, 1, 1, 0, 0, 0, 1, 1, 0);
    mult_t0_t1    = mk(8, 9, 1, 1, 0, 0, 0, 1, 0, 0);
    mflo_t2       = mk(0, 0, 0, 0, 10, 1, 0, 0, 0, 1);
    mthi_t0       = mk(8, 0, 1, 0, 0, 0, 0, 0, 0, 1);

    rst = 1'b1;
    model_clear();
    @(negedge clk);
    step(lw_t0, 1'b0);
    chk("reset_stall", int'(s_stall), 0);
    rst = 1'b0;
    drain(2);

    // lw then dependent addu: one-cycle stall, operand from WB
    issue(lw_t0, n);
    issue(addu_t2_t0_t1, n);
    chk("loaduse_stall_cycles", n, 1);
    chk("loaduse_fwd_a", int'(fwd_a_sel), 2);
    chk("loaduse_fwd_b", int'(fwd_b_sel), 0);
    drain(3);

    // back-to-back ALU dependency, then with an intervening nop
    issue(addu_t0_t1_t2, n);
    issue(subu_t3_t0_t0, n);
    chk("alu_stall_cycles", n, 0);
    chk("alu_fwd_a", int'(fwd_a_sel), 1);
    chk("alu_fwd_b", int'(fwd_b_sel), 1);
    issue(addu_t0_t1_t2, n);
    issue(nop, n);
    issue(subu_t3_t0_t0, n);
    chk("alu_nop_fwd_a", int'(fwd_a_sel), 2);
    chk("alu_nop_fwd_b", int'(fwd_b_sel), 2);
    drain(3);

    // writes to $0 never create a dependency
    issue(addu_z, n);
    issue(addu_t3_zz, n);
    chk("zero_stall_cycles", n, 0);
    chk("zero_fwd_a", int'(fwd_a_sel), 0);
    chk("zero_fwd_b", int'(fwd_b_sel), 0);
    drain(2);

    // HI/LO read waits out the whole div / mult latency
    issue(div_t0_t1, n);
    issue(mflo_t2, n);
    chk("div_mflo_stall_cycles", n, DIV_LAT);
    chk("div_busy_after", int'(md_busy), 0);
    issue(mult_t0_t1, n);
    issue(mflo_t2, n);
    chk("mult_mflo_stall_cycles", n, MULT_LAT);
    drain(2);

    // load-use and HI/LO stall overlapping: released only when busy falls
    issue(div_t0_t1, n);
    issue(lw_t0, n);
    issue(mthi_t0, n);
    chk("combined_stall_cycles", n, DIV_LAT - 1);
    drain(3);

    // redirect beats a load-use stall and kills the ID instruction
    issue(lw_t0, n);
    step(addu_t2_t0_t1, 1'b1);
    chk("redir_stall", int'(s_stall), 0);
    chk("redir_flush", int'(s_flush), 1);
    chk("redir_bubble", int'(s_bubble), 1);
    issue(addu_t2_t0_t1, n);
    chk("post_redir_stall_cycles", n, 0);
    chk("post_redir_fwd_a", int'(fwd_a_sel), 2);
    drain(2);

    // redirect suppresses a wrong-path div
    step(div_t0_t1, 1'b1);
    step('0, 1'b0);
    chk("redir_div_busy", int'(md_busy), 0);
    drain(2);

    // reset in the middle of a div clears everything at once
    issue(div_t0_t1, n);
    for (int k = 0; k < 9; k++) step(mflo_t2, 1'b0);
    chk("pre_reset_busy", int'(md_busy), 1);
    rst = 1'b1;
    step(mflo_t2, 1'b0);
    chk("midreset_stall", int'(s_stall), 0);
    chk("midreset_busy", int'(md_busy), 0);
    rst = 1'b0;
    issue(mflo_t2, n);
    chk("post_reset_mflo_stall_cycles", n, 0);
    drain(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
